mem_port_arbiter: RTL and testbench

Sequences and shares one single-ported, fixed-latency unified memory between two requesters: the instruction fetch port (IF) and the MEM-stage data port (D).
- D traffic covers loads, stores, and call/ret stack pushes and pops.
- The block serialises accesses and returns read data with a one-cycle ack.
- The pipeline derives its IF and MEM stalls from the req-and-not-ack outputs.
- D has priority. A starvation counter guarantees IF forward progress.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_lat_counter.sv | 34 +++
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam int WORD_W = 16;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter timing the fixed memory latency; last flags the final wait cycle.
module mem_lat_counter #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic last
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [CNT_W-1:0] cnt_r;

  // Latency count: load on issue, count down while waiting, park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (load) begin
      cnt_r <= CNT_LOAD;
    end else if (en && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign last = (cnt_r == CNT_ONE);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch (IF) and data (D) accesses onto one fixed-latency memory.
// D has priority; a saturating starvation counter forces an IF grant after STARVE_MAX D grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic              if_ack,
  output logic [WORD_W-1:0] if_rdata,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [WORD_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM  = STARVE_W'(STARVE_MAX);
  localparam logic [STARVE_W-1:0] STARVE_ONE  = STARVE_W'(1);
  localparam logic [STARVE_W-1:0] STARVE_ZERO = STARVE_W'(0);
  localparam logic [WORD_W-1:0]   WORD_ZERO   = {WORD_W{1'b0}};

  arb_state_e          state_r, state_s;
  logic [STARVE_W-1:0] starve_r, starve_s;
  logic                owner_r, owner_s;
  logic                we_r, we_s;
  logic                mem_en_r, mem_en_s;
  logic                mem_we_r, mem_we_s;
  logic [WORD_W-1:0]   mem_addr_r, mem_addr_s;
  logic [WORD_W-1:0]   mem_wdata_r, mem_wdata_s;
  logic                if_ack_r, if_ack_s;
  logic                d_ack_r, d_ack_s;
  logic [WORD_W-1:0]   if_rdata_r, if_rdata_s;
  logic [WORD_W-1:0]   d_rdata_r, d_rdata_s;
  logic                busy_r, busy_s;
  logic                d_req_s, grant_d_s;
  logic                lat_load_s, lat_en_s, lat_last_s;
  logic [WORD_W-1:0]   rdata_s;

  mem_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
    .clk  (clk),
    .rst  (rst),
    .load (lat_load_s),
    .en   (lat_en_s),
    .last (lat_last_s)
  );

  // Next-state and next-output decode; every output is produced one register stage later.
  always_comb begin
    state_s     = state_r;
    starve_s    = starve_r;
    owner_s     = owner_r;
    we_s        = we_r;
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    if_ack_s    = 1'b0;
    d_ack_s     = 1'b0;
    if_rdata_s  = if_rdata_r;
    d_rdata_s   = d_rdata_r;
    lat_load_s  = 1'b0;
    lat_en_s    = 1'b0;
    d_req_s     = d_re | d_we;
    grant_d_s   = d_req_s && (!if_req || (starve_r < STARVE_LIM));
    rdata_s     = we_r ? WORD_ZERO : mem_rdata;

    case (state_r)
      IDLE: begin
        if (grant_d_s) begin
          state_s     = ISSUE;
          owner_s     = OWNER_D;
          we_s        = d_we;
          mem_en_s    = 1'b1;
          mem_we_s    = d_we;
          mem_addr_s  = d_addr;
          mem_wdata_s = d_wdata;
          if (if_req) begin
            starve_s = (starve_r == STARVE_LIM) ? starve_r : (starve_r + STARVE_ONE);
          end else begin
            starve_s = STARVE_ZERO;
          end
        end else if (if_req) begin
          state_s     = ISSUE;
          owner_s     = OWNER_IF;
          we_s        = 1'b0;
          mem_en_s    = 1'b1;
          mem_we_s    = 1'b0;
          mem_addr_s  = if_addr;
          mem_wdata_s = WORD_ZERO;
          starve_s    = STARVE_ZERO;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        lat_load_s = 1'b1;
        state_s    = WAIT;
      end
      WAIT: begin
        lat_en_s = 1'b1;
        // The ack register doubles as the capture register, so data lands with the pulse.
        if (lat_last_s) begin
          state_s = DONE;
          if (owner_r == OWNER_D) begin
            d_ack_s   = 1'b1;
            d_rdata_s = rdata_s;
          end else begin
            if_ack_s   = 1'b1;
            if_rdata_s = rdata_s;
          end
        end else begin
          state_s = WAIT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State and registered-output update; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      starve_r    <= STARVE_ZERO;
      owner_r     <= OWNER_IF;
      we_r        <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= WORD_ZERO;
      mem_wdata_r <= WORD_ZERO;
      if_ack_r    <= 1'b0;
      d_ack_r     <= 1'b0;
      if_rdata_r  <= WORD_ZERO;
      d_rdata_r   <= WORD_ZERO;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      starve_r    <= starve_s;
      owner_r     <= owner_s;
      we_r        <= we_s;
      mem_en_r    <= mem_en_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      if_ack_r    <= if_ack_s;
      d_ack_r     <= d_ack_s;
      if_rdata_r  <= if_rdata_s;
      d_rdata_r   <= d_rdata_s;
      busy_r      <= busy_s;
    end
  end

  assign if_ack    = if_ack_r;
  assign if_rdata  = if_rdata_r;
  assign d_ack     = d_ack_r;
  assign d_rdata   = d_rdata_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign busy      = busy_r;
  assign owner     = owner_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: main instance at MEM_LAT=2, plus MEM_LAT=1 and 8 instances.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  // ---------------- main DUT (MEM_LAT=2, STARVE_MAX=4) ----------------
  logic        if_req = 1'b0, d_re = 1'b0, d_we = 1'b0;
  logic [15:0] if_addr = 16'h0000, d_addr = 16'h0000, d_wdata = 16'h0000;
  logic        if_ack, d_ack, mem_en, mem_we, busy, owner;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  // Memory models: a read sampled at an edge is visible MEM_LAT-1 cycles later, else garbage.
  logic [7:0]  m_vld = 8'h00;
  logic [15:0] m_dat [8];
  always @(posedge clk) begin
    for (int i = 7; i > 0; i--) begin
      m_vld[i] <= m_vld[i-1];
      m_dat[i] <= m_dat[i-1];
    end
    m_vld[0] <= mem_en && !mem_we;
    m_dat[0] <= mem_word(mem_addr);
  end
  assign mem_rdata = m_vld[1] ? m_dat[1] : 16'h0BAD;

  // ---------------- MEM_LAT=1 instance ----------------
  logic        l1_d_re = 1'b0;
  logic [15:0] l1_addr = 16'h0000;
  logic        l1_if_ack, l1_d_ack, l1_mem_en, l1_mem_we, l1_busy, l1_owner;
  logic [15:0] l1_if_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut_l1 (
    .clk(clk), .rst(rst),
    .if_req(1'b0), .if_addr(16'h0000), .if_ack(l1_if_ack), .if_rdata(l1_if_rdata),
    .d_re(l1_d_re), .d_we(1'b0), .d_addr(l1_addr), .d_wdata(16'h0000),
    .d_ack(l1_d_ack), .d_rdata(l1_d_rdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata), .busy(l1_busy), .owner(l1_owner)
  );

  logic [7:0]  l1_vld = 8'h00;
  logic [15:0] l1_dat [8];
  always @(posedge clk) begin
    for (int i = 7; i > 0; i--) begin
      l1_vld[i] <= l1_vld[i-1];
      l1_dat[i] <= l1_dat[i-1];
    end
    l1_vld[0] <= l1_mem_en && !l1_mem_we;
    l1_dat[0] <= mem_word(l1_mem_addr);
  end
  assign l1_mem_rdata = l1_vld[0] ? l1_dat[0] : 16'h0BAD;

  // ---------------- MEM_LAT=8 instance ----------------
  logic        l8_d_re = 1'b0;
  logic [15:0] l8_addr = 16'h0000;
  logic        l8_if_ack, l8_d_ack, l8_mem_en, l8_mem_we, l8_busy, l8_owner;
  logic [15:0] l8_if_rdata, l8_d_rdata, l8_mem_addr, l8_mem_wdata, l8_mem_rdata;

  mem_port_arbiter #(.MEM_LAT(8), .STARVE_MAX(4)) dut_l8 (
    .clk(clk), .rst(rst),
    .if_req(1'b0), .if_addr(16'h0000), .if_ack(l8_if_ack), .if_rdata(l8_if_rdata),
    .d_re(l8_d_re), .d_we(1'b0), .d_addr(l8_addr), .d_wdata(16'h0000),
    .d_ack(l8_d_ack), .d_rdata(l8_d_rdata),
    .mem_en(l8_mem_en), .mem_we(l8_mem_we), .mem_addr(l8_mem_addr), .mem_wdata(l8_mem_wdata),
    .mem_rdata(l8_mem_rdata), .busy(l8_busy), .owner(l8_owner)
  );

  logic [7:0]  l8_vld = 8'h00;
  logic [15:0] l8_dat [8];
  always @(posedge clk) begin
    for (int i = 7; i > 0; i--) begin
      l8_vld[i] <= l8_vld[i-1];
      l8_dat[i] <= l8_dat[i-1];
    end
    l8_vld[0] <= l8_mem_en && !l8_mem_we;
    l8_dat[0] <= mem_word(l8_mem_addr);
  end
  assign l8_mem_rdata = l8_vld[7] ? l8_dat[7] : 16'h0BAD;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int          n_en, en_at, if_at, d_at, overlap, n_ifack, n_dack;
  logic [15:0] en_addr, en_wdata, if_dat, d_dat, if_hold_d, d_hold_if;
  logic        en_we, if_own, d_own;

  // Runs ncyc cycles, logging mem strobes and acks; each requester drops its request on its ack.
  task automatic run(input int ncyc);
    n_en = 0; en_at = 0; if_at = 0; d_at = 0; overlap = 0; n_ifack = 0; n_dack = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      if (mem_en) begin
        n_en++; en_at = c; en_addr = mem_addr; en_we = mem_we; en_wdata = mem_wdata;
      end
      if (if_ack && d_ack) overlap++;
      if (if_ack) begin
        n_ifack++;
        if (if_at == 0) begin
          if_at = c; if_dat = if_rdata; if_own = owner; if_hold_d = d_rdata;
        end
        if_req = 1'b0;
      end
      if (d_ack) begin
        n_dack++;
        if (d_at == 0) begin
          d_at = c; d_dat = d_rdata; d_own = owner; d_hold_if = if_rdata;
        end
        d_re = 1'b0; d_we = 1'b0;
      end
    end
  endtask

  int         k;
  logic [9:0] seq;
  int         a_n, a_at1, a_at2, b_n, b_at1, b_at2;
  logic [15:0] a_dat1, a_dat2, b_dat1, b_dat2;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'({if_ack, d_ack, mem_en, mem_we, busy, owner}), 32'h0);
    chk("rst_rdata", {if_rdata, d_rdata}, 32'h0);
    chk("rst_mem", {mem_addr, mem_wdata}, 32'h0);
    rst = 1'b0;

    // Single fetch
    if_addr = 16'h0040; if_req = 1'b1;
    run(12);
    chk("fetch_en_cnt", n_en, 1);
    chk("fetch_en_cycle", en_at, 1);
    chk("fetch_addr", 32'(en_addr), 32'h0040);
    chk("fetch_we", 32'(en_we), 32'h0);
    chk("fetch_ack_cycle", if_at, 4);
    chk("fetch_rdata", 32'(if_dat), 32'hBEEF);
    chk("fetch_no_dack", n_dack, 0);
    chk("fetch_busy_after", 32'(busy), 32'h0);
    chk("fetch_owner", 32'(owner), 32'h0);

    // Simultaneous IF and D read: D first
    if_addr = 16'h0100; if_req = 1'b1;
    d_addr = 16'h0200; d_re = 1'b1;
    run(16);
    chk("both_d_ack_cycle", d_at, 4);
    chk("both_if_ack_cycle", if_at, 9);
    chk("both_d_owner", 32'(d_own), 32'h1);
    chk("both_if_owner", 32'(if_own), 32'h0);
    chk("both_d_rdata", 32'(d_dat), 32'h585A);
    chk("both_if_rdata", 32'(if_dat), 32'h5B5A);
    chk("both_if_hold", 32'(d_hold_if), 32'hBEEF);
    chk("both_d_hold", 32'(if_hold_d), 32'h585A);
    chk("both_overlap", overlap, 0);
    chk("both_en_cnt", n_en, 2);

    // Call push (write)
    d_addr = 16'hFFFE; d_wdata = 16'h0123; d_we = 1'b1;
    run(8);
    chk("push_en_cycle", en_at, 1);
    chk("push_we", 32'(en_we), 32'h1);
    chk("push_addr", 32'(en_addr), 32'hFFFE);
    chk("push_wdata", 32'(en_wdata), 32'h0123);
    chk("push_ack_cycle", d_at, 4);
    chk("push_rdata", 32'(d_dat), 32'h0000);

    // Starvation: IF held while D requests continuously
    if_addr = 16'h0300; if_req = 1'b1;
    d_addr = 16'h0400; d_re = 1'b1;
    k = 0; seq = 10'b0;
    for (int c = 1; c <= 80 && k < 10; c++) begin
      @(posedge clk); #1;
      if (if_ack || d_ack) begin
        seq[k] = d_ack;
        k++;
        if (k == 10) begin
          if_req = 1'b0; d_re = 1'b0;
        end
      end
    end
    chk("starve_acks", k, 10);
    chk("starve_order", 32'(seq), 32'h1EF);
    @(posedge clk); #1;
    chk("starve_if_rdata", 32'(if_rdata), 32'h595A);

    // Reset while a D read waits on memory
    d_addr = 16'h0500; d_re = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstw_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("rstw_ctrl", 32'({if_ack, d_ack, mem_en, mem_we, busy, owner}), 32'h0);
    chk("rstw_rdata", {if_rdata, d_rdata}, 32'h0);
    chk("rstw_mem", {mem_addr, mem_wdata}, 32'h0);
    d_re = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run(10);
    chk("rstw_no_dack", n_dack, 0);
    chk("rstw_no_en", n_en, 0);
    d_addr = 16'h0600; d_re = 1'b1;
    run(8);
    chk("rstw_next_ack_cycle", d_at, 4);
    chk("rstw_next_rdata", 32'(d_dat), 32'h5C5A);

    // Latency extremes: back-to-back reads at 0x0010 then 0x0012
    l1_addr = 16'h0010; l1_d_re = 1'b1;
    l8_addr = 16'h0010; l8_d_re = 1'b1;
    a_n = 0; a_at1 = 0; a_at2 = 0; b_n = 0; b_at1 = 0; b_at2 = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (l1_d_ack) begin
        a_n++;
        if (a_n == 1) begin
          a_at1 = c; a_dat1 = l1_d_rdata; l1_addr = 16'h0012;
        end else begin
          a_at2 = c; a_dat2 = l1_d_rdata; l1_d_re = 1'b0;
        end
      end
      if (l8_d_ack) begin
        b_n++;
        if (b_n == 1) begin
          b_at1 = c; b_dat1 = l8_d_rdata; l8_addr = 16'h0012;
        end else begin
          b_at2 = c; b_dat2 = l8_d_rdata; l8_d_re = 1'b0;
        end
      end
    end
    chk("l1_ack_cnt", a_n, 2);
    chk("l1_lat_first", a_at1, 3);
    chk("l1_lat_second", a_at2 - a_at1 - 1, 3);
    chk("l1_rdata_first", 32'(a_dat1), 32'h5A4A);
    chk("l1_rdata_second", 32'(a_dat2), 32'h5A48);
    chk("l8_ack_cnt", b_n, 2);
    chk("l8_lat_first", b_at1, 10);
    chk("l8_lat_second", b_at2 - b_at1 - 1, 10);
    chk("l8_rdata_first", 32'(b_dat1), 32'h5A4A);
    chk("l8_rdata_second", 32'(b_dat2), 32'h5A48);
    chk("lx_idle", 32'({l1_busy, l8_busy, l1_if_ack, l8_if_ack}), 32'h0);
    chk("lx_owner", 32'({l1_owner, l8_owner}), 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
